spi_slave: RTL and testbench

//  SPI responder peripheral on the CPU peripheral bus. An external SPI master clocks

---
 rtl/spi_slave.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_spi_slave.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//
// SPI responder on the CPU peripheral bus. An external SPI master clocks one
// byte at a time into RXDATA and out of the TX buffer. The top level decodes
// the peripheral window and drives addr/din/wr_en/rd_en. Read data on dout is
// muxed into the CPU read bus.
//
// Register map (offset = addr[ADDR_LSB+OPT_MEM_ADDR_BITS:ADDR_LSB]):
//   0 CTRL   RW  {4'b0, irq_en, cpha, cpol, en}
//   1 STAT   R   {4'b0, busy, ovr, tx_empty, rx_full}  (read clears ovr)
//   2 TXDATA W   reads as 8'h00
//   3 RXDATA R   (read clears rx_full)
//
// Ports:
//   clk      system clock; the only clock domain
//   reset    synchronous, active-high reset
//   addr     peripheral address (only the offset field is decoded here)
//   din      CPU write data
//   dout     CPU read data, combinational, 8'h00 when rd_en is low
//   wr_en    write strobe, one write per high cycle
//   rd_en    read strobe, one read per high cycle
//   sclk     SPI clock from the master (asynchronous)
//   mosi     SPI data in (asynchronous)
//   ss_n     SPI select, active low (asynchronous)
//   miso     SPI data out (registered; holds its value when not driven)
//   miso_oe  1 = drive miso; the top level tri-states the pad when 0
//   irq      only with SPI_SLAVE_IRQ_EN: irq_en & (rx_full | ovr), registered
//
// Build option:
//   SPI_SLAVE_IRQ_EN  adds the irq output. Without it CTRL[3] is plain storage.
//
// SCLK must be no faster than clk/8 so that every SPI edge is seen after the
// two-flop synchronisers and DONE/LOAD fit between a sample edge and the next
// shift edge.
// -----------------------------------------------------------------------------
module spi_slave #(
  parameter int ADDR_LSB          = 0,
  parameter int OPT_MEM_ADDR_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       ss_n,
  output logic       miso,
  output logic       miso_oe
`ifdef SPI_SLAVE_IRQ_EN
  ,
  output logic       irq
`endif
);

  localparam int OFF_W = OPT_MEM_ADDR_BITS + 1;

  localparam logic [OFF_W-1:0] OFF_CTRL   = OFF_W'(0);
  localparam logic [OFF_W-1:0] OFF_STAT   = OFF_W'(1);
  localparam logic [OFF_W-1:0] OFF_TXDATA = OFF_W'(2);
  localparam logic [OFF_W-1:0] OFF_RXDATA = OFF_W'(3);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // Register state
  // ---------------------------------------------------------------------------
  state_t     state;
  logic [3:0] ctrl;        // {irq_en, cpha, cpol, en}
  logic [7:0] tx_buf;
  logic [7:0] tx_shift;
  logic [7:0] rx_shift;
  logic [7:0] rx_data;
  logic [2:0] bitcnt;
  logic       rx_full;
  logic       ovr;
  logic       tx_empty;
  logic       busy;

  logic ctrl_en;
  logic ctrl_cpol;
  logic ctrl_cpha;

  assign ctrl_en   = ctrl[0];
  assign ctrl_cpol = ctrl[1];
  assign ctrl_cpha = ctrl[2];

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic [OFF_W-1:0] offset;
  logic             wr_ctrl;
  logic             wr_tx;
  logic             rd_stat;
  logic             rd_rx;
  logic             unused_addr;

  assign offset  = addr[ADDR_LSB+OPT_MEM_ADDR_BITS:ADDR_LSB];
  assign wr_ctrl = wr_en && (offset == OFF_CTRL);
  assign wr_tx   = wr_en && (offset == OFF_TXDATA);
  assign rd_stat = rd_en && (offset == OFF_STAT);
  assign rd_rx   = rd_en && (offset == OFF_RXDATA);

  // Bits outside the offset field belong to the top-level window decode.
  assign unused_addr = ^addr;

  // ---------------------------------------------------------------------------
  // Input synchronisers and edge detection
  // ---------------------------------------------------------------------------
  logic [1:0] sclk_sync;
  logic [1:0] mosi_sync;
  logic [1:0] ss_n_sync;
  logic       sclk_q;
  logic       ss_n_q;

  // NOTE: synchronous reset lives inside the clocked block; reset is a plain
  // data input here, never in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b00;
      ss_n_sync <= 2'b11;
      sclk_q    <= 1'b0;
      ss_n_q    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop in this chain sample
      // its predecessor's old value, which is what builds a real shift chain.
      sclk_sync <= {sclk_sync[0], sclk};
      mosi_sync <= {mosi_sync[0], mosi};
      ss_n_sync <= {ss_n_sync[0], ss_n};
      sclk_q    <= sclk_sync[1];
      ss_n_q    <= ss_n_sync[1];
    end
  end

  logic sclk_s;
  logic mosi_s;
  logic ss_n_s;
  logic ss_fall;
  logic lead_edge;
  logic trail_edge;
  logic sample_edge;
  logic shift_edge;
  logic abort;

  assign sclk_s  = sclk_sync[1];
  assign mosi_s  = mosi_sync[1];
  assign ss_n_s  = ss_n_sync[1];
  assign ss_fall = ss_n_q && !ss_n_s;

  // Leading edge leaves the idle level cpol, trailing edge returns to it.
  assign lead_edge  = (sclk_q == ctrl_cpol) && (sclk_s != ctrl_cpol);
  assign trail_edge = (sclk_q != ctrl_cpol) && (sclk_s == ctrl_cpol);

  assign sample_edge = ctrl_cpha ? trail_edge : lead_edge;
  assign shift_edge  = ctrl_cpha ? lead_edge  : trail_edge;

  // Deselect or disable during a byte drops the partial byte.
  assign abort = ss_n_s || !ctrl_en;

  // An empty TX buffer sends zeros rather than repeating stale data.
  logic [7:0] load_byte;
  assign load_byte = tx_empty ? 8'h00 : tx_buf;

  // ---------------------------------------------------------------------------
  // Transfer FSM and CPU-visible registers
  //
  // Several fields are written both by the CPU side and by the FSM, so they
  // share one block. Statement order sets priority: the CPU clear strobes come
  // first so a completing byte (DONE) wins over a same-cycle RXDATA/STAT read,
  // and the TXDATA write comes last so a write in the LOAD cycle leaves
  // tx_empty at 0 while LOAD still takes the old buffer contents.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ctrl     <= 4'h0;
      tx_buf   <= 8'h00;
      tx_shift <= 8'h00;
      rx_shift <= 8'h00;
      rx_data  <= 8'h00;
      bitcnt   <= 3'd0;
      rx_full  <= 1'b0;
      ovr      <= 1'b0;
      tx_empty <= 1'b1;
      busy     <= 1'b0;
      miso     <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl    <= din[3:0];
      if (rd_rx)   rx_full <= 1'b0;
      if (rd_stat) ovr     <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (ctrl_en && ss_fall) state <= ST_LOAD;
        end

        ST_LOAD: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            tx_shift <= load_byte;
            tx_empty <= 1'b1;
            bitcnt   <= 3'd0;
            busy     <= 1'b1;
            // With cpha=0 the master samples bit 7 on the very first edge,
            // so it has to be on the wire before any SCLK activity.
            if (!ctrl_cpha) miso <= load_byte[7];
            state <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            if (sample_edge) begin
              rx_shift <= {rx_shift[6:0], mosi_s};
              bitcnt   <= bitcnt + 3'd1;
              if (bitcnt == 3'd7) state <= ST_DONE;
            end
            // cpha=0: bit 7 is already out, so each trailing edge presents the
            // next bit. The guard drops the previous byte's final trailing
            // edge, which arrives after LOAD during back-to-back bytes.
            // cpha=1: each leading edge presents the current MSB.
            if (shift_edge && (ctrl_cpha || (bitcnt != 3'd0))) begin
              miso     <= ctrl_cpha ? tx_shift[7] : tx_shift[6];
              tx_shift <= {tx_shift[6:0], 1'b0};
            end
          end
        end

        ST_DONE: begin
          rx_full <= 1'b1;
          if (!rx_full) rx_data <= rx_shift;
          else          ovr     <= 1'b1;
          if (ctrl_en && !ss_n_s) begin
            state <= ST_LOAD;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase

      if (wr_tx) begin
        tx_buf   <= din;
        tx_empty <= 1'b0;
      end
    end
  end

  assign miso_oe = ctrl_en && !ss_n_s;

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  // NOTE: dout gets a default before the case so every path assigns it and
  // no latch is inferred.
  always_comb begin
    dout = 8'h00;
    if (rd_en) begin
      case (offset)
        OFF_CTRL:   dout = {4'b0000, ctrl};
        OFF_STAT:   dout = {4'b0000, busy, ovr, tx_empty, rx_full};
        OFF_RXDATA: dout = rx_data;
        default:    dout = 8'h00;
      endcase
    end
  end

`ifdef SPI_SLAVE_IRQ_EN
  // ---------------------------------------------------------------------------
  // Interrupt: registered level, follows status one clock later.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else       irq <= ctrl[3] && (rx_full || ovr);
  end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
//
// Bit-bangs an SPI master against spi_slave in all four modes and drives the
// CPU bus. Expected MISO bytes and expected RXDATA bytes are queued when the
// stimulus that produces them is issued and popped when the DUT delivers them.
// -----------------------------------------------------------------------------
module tb_spi_slave;

  localparam int H = 6;  // SCLK half period in clk cycles

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       wr_en;
  logic       rd_en;
  logic       sclk;
  logic       mosi;
  logic       ss_n;
  logic       miso;
  logic       miso_oe;
`ifdef SPI_SLAVE_IRQ_EN
  logic       irq;
`endif

  logic cpol;
  logic cpha;

  int checks = 0;
  int errors = 0;

  logic [7:0] miso_q[$];
  logic [7:0] rx_q[$];

  spi_slave dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .din     (din),
    .dout    (dout),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .sclk    (sclk),
    .mosi    (mosi),
    .ss_n    (ss_n),
    .miso    (miso),
    .miso_oe (miso_oe)
`ifdef SPI_SLAVE_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete within the time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic cpu_write(input logic [7:0] off, input logic [7:0] data);
    @(negedge clk);
    addr  = off;
    din   = data;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] off, output logic [7:0] data);
    @(negedge clk);
    addr  = off;
    rd_en = 1'b1;
    #1 data = dout;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [7:0] off, input logic [7:0] exp);
    logic [7:0] v;
    cpu_read(off, v);
    check(tag, v, exp);
  endtask

  task automatic tx_write(input logic [7:0] b, input bit expect_out);
    cpu_write(8'd2, b);
    if (expect_out) miso_q.push_back(b);
  endtask

  task automatic check_miso(input logic [7:0] got);
    if (miso_q.size() == 0) check("miso_noexp", got, 8'hxx);
    else                    check("miso_byte", got, miso_q.pop_front());
  endtask

  task automatic read_rx(input string tag);
    logic [7:0] v;
    cpu_read(8'd3, v);
    if (rx_q.size() == 0) check({tag, "_noexp"}, v, 8'hxx);
    else                  check(tag, v, rx_q.pop_front());
  endtask

  task automatic set_mode(input logic [1:0] m, input logic irq_en);
    cpol = m[1];
    cpha = m[0];
    cpu_write(8'd0, {4'b0000, irq_en, cpha, cpol, 1'b1});
    sclk = cpol;
    repeat (4) @(negedge clk);
  endtask

  // Master side of one byte (or the first nbits of it). Returns the bits seen
  // on MISO and counts MISO changes in the half period following a sample
  // edge, where the slave must hold the line. With rd_at_done the RXDATA read
  // strobe is placed on the cycle the slave completes the byte (mode 0 only).
  task automatic spi_xfer(input logic [7:0] mosi_byte, input int nbits, input bit rd_at_done,
                          output logic [7:0] miso_byte, output int unstable);
    logic pre;
    bit   have_pre;
    miso_byte = 8'h00;
    unstable  = 0;
    have_pre  = 1'b0;
    pre       = 1'b0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      if (!cpha) mosi = mosi_byte[i];
      repeat (H - 1) @(negedge clk);
      if (have_pre && (miso !== pre)) unstable++;
      @(negedge clk);
      sclk = ~cpol;
      if (cpha) begin
        mosi = mosi_byte[i];
      end else begin
        miso_byte = {miso_byte[6:0], miso};
        pre       = miso;
      end
      if (rd_at_done && !cpha && (i == 0)) begin
        repeat (3) @(negedge clk);
        addr  = 8'd3;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        repeat (H - 4) @(negedge clk);
      end else begin
        repeat (H - 1) @(negedge clk);
        if (!cpha && (i != 0) && (miso !== pre)) unstable++;
        @(negedge clk);
      end
      sclk = cpol;
      if (cpha) begin
        miso_byte = {miso_byte[6:0], miso};
        pre       = miso;
        have_pre  = 1'b1;
      end
    end
  endtask

  task automatic end_frame();
    repeat (H) @(negedge clk);
    ss_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin : main
    logic [7:0] mb;
    logic [7:0] mb2;
    int         uns;

    reset = 1'b1;
    addr  = 8'h00;
    din   = 8'h00;
    wr_en = 1'b0;
    rd_en = 1'b0;
    sclk  = 1'b0;
    mosi  = 1'b0;
    ss_n  = 1'b1;
    cpol  = 1'b0;
    cpha  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    #1;
    check("rst_miso", {7'b0, miso}, 8'h00);
    check("rst_miso_oe", {7'b0, miso_oe}, 8'h00);
`ifdef SPI_SLAVE_IRQ_EN
    check("rst_irq", {7'b0, irq}, 8'h00);
`endif
    check_reg("rst_ctrl", 8'd0, 8'h00);
    check_reg("rst_stat", 8'd1, 8'h02);
    check_reg("rst_rxdata", 8'd3, 8'h00);
    check_reg("txdata_reads_zero", 8'd2, 8'h00);

    // Read-only registers ignore writes; CTRL keeps only its low nibble.
    cpu_write(8'd1, 8'hFF);
    cpu_write(8'd3, 8'hFF);
    check_reg("stat_ignores_wr", 8'd1, 8'h02);
    check_reg("rx_ignores_wr", 8'd3, 8'h00);
    cpu_write(8'd0, 8'hFA);
    check_reg("ctrl_rw", 8'd0, 8'h0A);
    @(negedge clk);
    addr  = 8'd0;
    rd_en = 1'b0;
    #1 check("dout_no_rd", dout, 8'h00);
    cpu_write(8'd0, 8'h00);

    // One byte in each mode: MISO carries TXDATA, RXDATA gets MOSI.
    for (int m = 0; m < 4; m++) begin
      set_mode(2'(m), 1'b0);
      tx_write(8'hA5, 1'b1);
      check_reg("stat_tx_loaded", 8'd1, 8'h00);
      ss_n = 1'b0;
      repeat (5) @(negedge clk);
      check_reg("stat_busy", 8'd1, 8'h0A);
      @(negedge clk);
      rx_q.push_back(8'h3C);
      spi_xfer(8'h3C, 8, 1'b0, mb, uns);
      end_frame();
      check_miso(mb);
      check("miso_stable", 8'(uns), 8'h00);
      check_reg("stat_after_byte", 8'd1, 8'h03);
      read_rx("rx_mode_byte");
      check_reg("stat_after_rd", 8'd1, 8'h02);
    end

    // Two bytes in one frame, TXDATA written once: second byte sends zeros and
    // overruns the unread RXDATA.
    set_mode(2'd0, 1'b0);
    tx_write(8'hA5, 1'b1);
    rx_q.push_back(8'h3C);
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
    spi_xfer(8'h3C, 8, 1'b0, mb, uns);
    miso_q.push_back(8'h00);
    spi_xfer(8'h81, 8, 1'b0, mb2, uns);
    end_frame();
    check_miso(mb);
    check_miso(mb2);
    check_reg("stat_ovr", 8'd1, 8'h07);
    check_reg("stat_ovr_cleared", 8'd1, 8'h03);
    read_rx("rx_keeps_first");

    // Deselect after 5 bits drops the partial byte.
    tx_write(8'h5A, 1'b0);
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
    spi_xfer(8'hFF, 5, 1'b0, mb, uns);
    end_frame();
    check_reg("stat_abort", 8'd1, 8'h02);
    tx_write(8'hC3, 1'b1);
    rx_q.push_back(8'h96);
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
    spi_xfer(8'h96, 8, 1'b0, mb, uns);
    end_frame();
    check_miso(mb);
    read_rx("rx_after_abort");

    // RXDATA read in the completing cycle: the new byte still lands.
    tx_write(8'hE7, 1'b1);
    rx_q.push_back(8'h4B);
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
    spi_xfer(8'h4B, 8, 1'b1, mb, uns);
    end_frame();
    check_miso(mb);
    check_reg("stat_rd_at_done", 8'd1, 8'h03);
    read_rx("rx_rd_at_done");

`ifdef SPI_SLAVE_IRQ_EN
    // Interrupt follows rx_full only while irq_en is set.
    set_mode(2'd0, 1'b1);
    @(negedge clk);
    check("irq_idle", {7'b0, irq}, 8'h00);
    tx_write(8'h11, 1'b1);
    rx_q.push_back(8'h55);
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
    spi_xfer(8'h55, 8, 1'b0, mb, uns);
    end_frame();
    check_miso(mb);
    check("irq_on_byte", {7'b0, irq}, 8'h01);
    read_rx("rx_irq_byte");
    repeat (2) @(negedge clk);
    check("irq_cleared", {7'b0, irq}, 8'h00);
    set_mode(2'd0, 1'b0);
    tx_write(8'h22, 1'b1);
    rx_q.push_back(8'h66);
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
    spi_xfer(8'h66, 8, 1'b0, mb, uns);
    end_frame();
    check_miso(mb);
    check("irq_masked", {7'b0, irq}, 8'h00);
    read_rx("rx_masked_byte");
`endif

    // Reset in the middle of a byte with MISO high.
    set_mode(2'd0, 1'b0);
    tx_write(8'hFF, 1'b0);
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
    spi_xfer(8'hFF, 4, 1'b0, mb, uns);
    repeat (3) @(negedge clk);
    check("pre_reset_miso", {7'b0, miso}, 8'h01);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_miso", {7'b0, miso}, 8'h00);
    check("mid_rst_miso_oe", {7'b0, miso_oe}, 8'h00);
`ifdef SPI_SLAVE_IRQ_EN
    check("mid_rst_irq", {7'b0, irq}, 8'h00);
`endif
    ss_n = 1'b1;
    sclk = 1'b0;
    check_reg("mid_rst_ctrl", 8'd0, 8'h00);
    check_reg("mid_rst_stat", 8'd1, 8'h02);
    check_reg("mid_rst_rxdata", 8'd3, 8'h00);

    check("miso_q_drained", 8'(miso_q.size()), 8'h00);
    check("rx_q_drained", 8'(rx_q.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
